// File: rtl/snn_pkg.sv
// snn_pkg: packet layout, router ids, opcodes and feeder state shared by the SNN fabric
package snn_pkg;
  localparam int PKT_W   = 33;
  localparam int DEST_HI = 32;
  localparam int DEST_LO = 29;
  localparam int OP_HI   = 28;
  localparam int OP_LO   = 25;
  localparam int DATA_HI = 24;
  localparam int DATA_LO = 0;
  localparam int IMEM_ID = 10;
  localparam logic [3:0] OP_WEIGHTS_DONE     = 4'd0;
  localparam logic [3:0] OP_PPE_INPUT        = 4'd1;
  localparam logic [3:0] OP_PPE_5_REQ_INPUT  = 4'd5;
  localparam logic [3:0] OP_PPE_6_REQ_INPUT  = 4'd6;
  localparam logic [3:0] OP_PPE_7_REQ_INPUT  = 4'd7;
  localparam logic [3:0] OP_PPE_8_REQ_INPUT  = 4'd8;
  localparam logic [3:0] OP_PPE_9_REQ_INPUT  = 4'd9;
  localparam logic [3:0] OP_TIMESTEP_DONE    = 4'd10;
  typedef enum logic [1:0] {IDLE, STREAM, REQ, DONE} feeder_state_t;
endpackage

// File: rtl/ppe_row_feeder.sv
// ppe_row_feeder: buffers one IFMAP row and streams sliding windows to a PE, requesting further rows
module ppe_row_feeder
  import snn_pkg::*;
#(
  parameter int PE_ID       = 5,
  parameter int IMEM_ID     = snn_pkg::IMEM_ID,
  parameter int IFMAP_SIZE  = 25,
  parameter int FILTER_SIZE = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PKT_W-1:0]       in_packet,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [FILTER_SIZE-1:0] win_data,
  output logic [4:0]             win_col,
  output logic [2:0]             win_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PKT_W-1:0]       out_packet,
  output logic                   ts_done,
  output logic                   bad_pkt
);
  localparam logic [4:0] LAST_COL = 5'(IFMAP_SIZE - FILTER_SIZE);
  localparam logic [2:0] LAST_ROW = 3'(FILTER_SIZE - 1);
  localparam logic [PKT_W-1:0] REQ_PKT = {4'(IMEM_ID), 4'(PE_ID), {(DATA_HI + 1){1'b0}}};
  feeder_state_t r_state;
  logic [IFMAP_SIZE-1:0] r_row_reg;
  logic [4:0] r_col;
  logic [2:0] r_row_cnt;
  logic r_in_ready, r_win_valid, r_out_valid, r_ts_done, r_bad_pkt;
  logic [FILTER_SIZE-1:0] r_win_data;
  logic [4:0] r_win_col;
  logic [2:0] r_win_row;
  logic [PKT_W-1:0] r_out_packet;
  logic [4:0] w_ncol;
  logic w_xfer, w_good, w_win_hs;
  assign w_ncol   = r_col + 5'd1;
  assign w_xfer   = in_valid & r_in_ready;
  assign w_good   = in_packet[DEST_HI:DEST_LO] == 4'(PE_ID) && in_packet[OP_HI:OP_LO] == OP_PPE_INPUT;
  assign w_win_hs = r_win_valid & win_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_row_reg    <= '0;
      r_col        <= '0;
      r_row_cnt    <= '0;
      r_in_ready   <= 1'b0;
      r_win_valid  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_ts_done    <= 1'b0;
      r_bad_pkt    <= 1'b0;
      r_win_data   <= '0;
      r_win_col    <= '0;
      r_win_row    <= '0;
      r_out_packet <= '0;
    end else begin
      r_bad_pkt <= 1'b0;
      r_ts_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_in_ready <= !(w_xfer && w_good);
          if (w_xfer && w_good) begin
            r_row_reg   <= in_packet[DATA_HI:DATA_LO];
            r_col       <= '0;
            r_state     <= STREAM;
            r_win_valid <= 1'b1;
            r_win_data  <= in_packet[FILTER_SIZE-1:0];
            r_win_col   <= '0;
            r_win_row   <= r_row_cnt;
          end else if (w_xfer) r_bad_pkt <= 1'b1;
        end
        STREAM: begin
          if (w_win_hs && r_col == LAST_COL) begin
            r_win_valid <= 1'b0;
            // row_cnt is cleared on the way into DONE so it never leaves 0..FILTER_SIZE-1
            if (r_row_cnt == LAST_ROW) begin
              r_row_cnt <= '0;
              r_ts_done <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_row_cnt    <= r_row_cnt + 3'd1;
              r_out_valid  <= 1'b1;
              r_out_packet <= REQ_PKT;
              r_state      <= REQ;
            end
          end else if (w_win_hs) begin
            r_col      <= w_ncol;
            r_win_data <= r_row_reg[w_ncol +: FILTER_SIZE];
            r_win_col  <= w_ncol;
          end
        end
        REQ: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        DONE: begin
          r_row_cnt  <= '0;
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready   = r_in_ready;
  assign win_valid  = r_win_valid;
  assign win_data   = r_win_data;
  assign win_col    = r_win_col;
  assign win_row    = r_win_row;
  assign out_valid  = r_out_valid;
  assign out_packet = r_out_packet;
  assign ts_done    = r_ts_done;
  assign bad_pkt    = r_bad_pkt;
endmodule

// File: doc/ppe_row_feeder.md
PPE_ROW_FEEDER -- requirements
Module: ppe_row_feeder

Interface
REQ-001 SHALL have parameter PE_ID, default 5, meaning the destination address of this feeder (legal 5..9).
REQ-002 SHALL have parameter IMEM_ID, default 10, meaning the IFMAP memory router address.
REQ-003 SHALL have parameter IFMAP_SIZE, default 25, meaning the row width in bits.
REQ-004 SHALL have parameter FILTER_SIZE, default 5, meaning the window width and rows per timestep.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-007 SHALL have ports in_valid (in, 1), in_ready (out, 1) and in_packet (in, 33), meaning the router-to-feeder packet channel.
REQ-008 SHALL have ports win_valid (out, 1), win_ready (in, 1), win_data (out, 5), win_col (out, 5) and win_row (out, 3), meaning the window stream to the PE.
REQ-009 SHALL have ports out_valid (out, 1), out_ready (in, 1) and out_packet (out, 33), meaning the request channel to the router.
REQ-010 SHALL have port ts_done, output, 1, meaning a one-cycle pulse when all rows of a timestep have streamed.
REQ-011 SHALL have port bad_pkt, output, 1, meaning a one-cycle pulse when a packet is dropped.

Function
REQ-012 SHALL use packet fields [32:29] dest, [28:25] opcode and [24:0] data.
REQ-013 SHALL use the states IDLE, STREAM, REQ and DONE.
REQ-014 SHALL assert in_ready only in IDLE; a transfer is in_valid&in_ready.
REQ-015 SHALL, in IDLE, latch data into row_reg on a transfer with dest==PE_ID and opcode==OP_PPE_INPUT (1), clear col to 0, and go to STREAM.
REQ-016 SHALL, in IDLE, accept and discard any other packet, pulse bad_pkt the next cycle, and stay in IDLE.
REQ-017 SHALL, in STREAM, hold win_valid=1 with win_data=row_reg[col+4:col] (bit 0 is column 0), win_col=col and win_row=row_cnt.
REQ-018 SHALL hold all window outputs stable while win_valid&!win_ready.
REQ-019 SHALL increment col on each win handshake.
REQ-020 SHALL, on the handshake at col==IFMAP_SIZE-FILTER_SIZE (20), increment row_cnt; go to REQ if the new row_cnt<FILTER_SIZE, else go to DONE.
REQ-021 SHALL give a latency of exactly 1 cycle from the accepting edge to the first win_valid=1.
REQ-022 SHALL give a throughput of 1 window per cycle when win_ready is held at 1.
REQ-023 SHALL, in REQ, drive out_valid=1 and out_packet={IMEM_ID, PE_ID[3:0], 25'b0}, held stable until out_ready.
REQ-024 SHALL go to IDLE on the out handshake in REQ.
REQ-025 SHALL, in DONE, pulse ts_done for one cycle, clear row_cnt to 0, and return to IDLE on the next cycle.
REQ-026 SHALL expect the first row of each timestep unsolicited, with no request; there are exactly FILTER_SIZE-1 (4) requests per timestep.
REQ-027 SHALL never assert win_valid, out_valid and in_ready in the same cycle; the states are mutually exclusive.
REQ-028 SHALL keep col within 0..20 and row_cnt within 0..4; neither ever wraps without passing through the transitions in REQ-020 and REQ-025.

Reset
REQ-029 SHALL, on rst_n low and at any time including mid-STREAM or mid-REQ, immediately force state=IDLE.
REQ-030 SHALL reset col=0, row_cnt=0 and row_reg=0.
REQ-031 SHALL reset win_valid=0, out_valid=0, ts_done=0 and bad_pkt=0.
REQ-032 SHALL reset in_ready to 0 while rst_n is low and drive it to 1 from the first edge after release.
REQ-033 SHALL reset win_data, win_col, win_row and out_packet to 0.
REQ-034 SHALL not emit a pending request after reset.

Structure
REQ-035 SHALL take the opcode constants (OP_WEIGHTS_DONE=0, OP_PPE_INPUT=1, OP_PPE_5..9_REQ_INPUT=5..9, OP_TIMESTEP_DONE=10), the packet field bounds, IMEM_ID and the state enum typedef from a shared package snn_pkg.
REQ-036 SHALL be a single module with no sub-module; the window extraction is an indexed part-select inside it.

Verification
REQ-037 SHALL verify single row: packet {5,1,25'h0000001F} with win_ready=1 -> win_valid on cycles 1..21, win_data 5'h1F at col 0, 5'h0F at col 1, ... 5'h00 at col 5..20, then out_packet {10,5,0}.
REQ-038 SHALL verify backpressure: win_ready toggled 0/1 -> win_data, win_col and win_row unchanged during stalls, and 21 handshakes total.
REQ-039 SHALL verify full timestep: 5 rows delivered after each of 4 requests -> exactly 4 out transfers, win_row 0..4, and one ts_done pulse; a 6th packet restarts at win_row 0.
REQ-040 SHALL verify filtering: packet dest 6 or opcode 0 -> bad_pkt pulse, no win_valid, state stays IDLE.
REQ-041 SHALL verify reset mid-stream: rst_n low at col 10 -> next cycle win_valid 0 and in_ready 0; after release in_ready 1 and row_cnt 0.
REQ-042 SHALL verify request stall: out_ready held 0 for 7 cycles in REQ -> out_packet stable and in_ready stays 0 throughout.
